seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Time-multiplexed driver for a bank of common-anode seven-segment digits. It takes a packed hex word plus per-digit decimal-point and blank masks and scans one digit per refresh slot. It inserts an anti-ghosting guard interval at the start of each slot. Display data is double-buffered so that updates apply only at a frame boundary, and the bank never shows a torn value. It sits between the datapath/register file and the board anode/segment pins, and replaces the single-digit combinational decoder in multi-digit designs.

## Interface
- DIGITS, 4: number of digits scanned, legal 1..8.
- CLK_DIV, 50000: clock cycles per digit slot, legal >= 2.
- GUARD, 16: blanked cycles at the start of each slot, legal 0..CLK_DIV-1.
- CLK  input  1  system clock; all logic is on the rising edge.
- RST  input  1  synchronous, active-high reset.
- VALUE  input  4*DIGITS  hex nibbles; digit i is VALUE[4i+3:4i], and digit 0 is the rightmost.
- DP  input  DIGITS  decimal-point enables, active high.
- BLANK  input  DIGITS  per-digit blank, active high; blanks both segments and the decimal point.
- LOAD  input  1  single-cycle strobe that captures VALUE/DP/BLANK into the pending buffer.
- LZS  input  1  leading-zero suppression mode, sampled live every cycle.
- SEG  output  7  segment drive, active low.
- DOT  output  1  decimal-point drive, active low.
- AN  output  DIGITS  anode enables, active low, one-hot-low when a digit is lit.
- BUSY  output  1  high while a load is pending and not yet applied.
- FRAME  output  1  one-cycle pulse at each frame boundary.

## Operation
- Segment encoding, active low, for nibble 0..F in order: 0001000, 1101101, 0100010, 0100100, 1000101, 0010100, 0010000, 0101101, 0000000, 0000100, 0000001, 1010000, 0011010, 1100000, 0010010, 0010011. "All off" is 1111111.
- State:
  - prescaler cnt counts 0..CLK_DIV-1;
  - digit index idx counts 0..DIGITS-1;
  - pending buffer PB holds VALUE/DP/BLANK;
  - pend flag;
  - shadow register SH holds the displayed data.
- Each cycle cnt increments. When cnt == CLK_DIV-1, cnt wraps to 0 and idx increments, wrapping DIGITS-1 -> 0.
- A frame boundary is the edge at which cnt == CLK_DIV-1 and idx == DIGITS-1. At that edge:
  - FRAME is set for one cycle;
  - if pend == 1, SH <= PB and pend clears.
- LOAD high: PB <= {VALUE, DP, BLANK} and pend <= 1. A later LOAD before the boundary overwrites PB; the last one wins.
- LOAD on the boundary edge: the transfer uses the old PB contents. The new data is written into PB and pend stays 1. The new data is therefore applied at the next boundary.
- Output selection for slot idx:
  - guard (cnt < GUARD): AN all 1, SEG = 1111111, DOT = 1;
  - else if SH.BLANK[idx]: AN all 1, SEG = 1111111, DOT = 1;
  - else if LZS, idx != 0, and SH digits idx..DIGITS-1 are all 0: AN lit, SEG = 1111111, DOT = ~SH.DP[idx];
  - else: AN[idx] = 0 and all other AN bits 1, SEG = encode(SH digit idx), DOT = ~SH.DP[idx].
- Digit 0 is never zero-suppressed.
- DIGITS = 1: idx is constant 0, and FRAME pulses every CLK_DIV cycles.

## Timing
- Reset values:
  - cnt = 0, idx = 0, pend = 0;
  - PB = 0, SH = 0 (all digits 0, DP 0, BLANK 0);
  - SEG = 1111111, DOT = 1, AN = all 1;
  - BUSY = 0, FRAME = 0.
- SEG, DOT, AN and FRAME are registered. They reflect the (cnt, idx, SH) state present before the edge, so they lag the counters by one cycle.
- BUSY = pend, also registered. It rises the cycle after LOAD and falls the cycle after the boundary that applies the data.
- Worst-case LOAD-to-display latency is DIGITS*CLK_DIV + 1 cycles.
- RST asserted mid-operation, including mid-slot or with a load pending: all state returns to reset values at that edge, and pending data is discarded.
- RST has priority over LOAD.

## Test plan
- DIGITS=4, CLK_DIV=4, GUARD=1, after reset:
  - AN cycles 1111, 1110, 1110, 1110, then 1111, 1101, ...;
  - with SH = 0 the lit slots show SEG = 0001000;
  - FRAME pulses every 16 cycles.
- LOAD VALUE=16'h1A2F, DP=4'b0010, mid-frame:
  - BUSY goes high;
  - display unchanged until the boundary;
  - the next frame shows SEG 0010011, 0100010, 0000001, 1101101 for digits 0..3;
  - DOT = 0 only on digit 1;
  - BUSY drops.
- Two LOADs in one frame (16'h1111 then 16'h2222): only 2222 is ever displayed.
- LOAD on the boundary edge with a pend already set: old PB is applied, the new value is applied one frame later, and BUSY stays high in between.
- LZS=1, VALUE=16'h0070:
  - digits 3 and 2 are AN-lit with SEG 1111111;
  - digits 1 and 0 show 0101101 and 0001000;
  - BLANK=4'b0001 turns AN fully off in slot 0.
- RST pulsed mid-slot with pend=1: the next cycle has AN all 1, BUSY=0 and cnt=idx=0, and the pending data is never shown.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode seven-segment scanner with guard blanking,
// leading-zero suppression and frame-synchronous double-buffered display data.

module seven_seg_scanner_chk #(
  parameter int unsigned DIGITS = 4
) (
  input logic              clk,
  input logic              rst,
  input logic [6:0]        seg,
  input logic              dot,
  input logic [DIGITS-1:0] an
);

  // At most one anode may be driven low at any time.
  an_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(~an));

  // With every anode off, the segment and dot drives must also be dark.
  an_dark: assert property (@(posedge clk) disable iff (rst)
    (an == {DIGITS{1'b1}}) |-> ((seg == 7'b1111111) && dot));

endmodule

module seven_seg_scanner #(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned CLK_DIV = 50000,
  parameter int unsigned GUARD   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  input  logic                  lzs,
  output logic [6:0]            seg,
  output logic                  dot,
  output logic [DIGITS-1:0]     an,
  output logic                  busy,
  output logic                  frame
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;
  logic                   pend;
  logic [4*DIGITS-1:0]    pb_value;
  logic [DIGITS-1:0]      pb_dp;
  logic [DIGITS-1:0]      pb_blank;
  logic [4*DIGITS-1:0]    sh_value;
  logic [DIGITS-1:0]      sh_dp;
  logic [DIGITS-1:0]      sh_blank;

  logic                   cnt_last;
  logic                   boundary;
  logic                   in_guard;
  logic [3:0]             cur_nib;
  logic [DIGITS-1:0]      an_sel;
  logic [DIGITS-1:0]      upper_zero;
  logic                   zero_run;
  logic [6:0]             seg_nxt;
  logic                   dot_nxt;
  logic [DIGITS-1:0]      an_nxt;

  function automatic logic [6:0] encode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b0001000;
      4'h1:    pat = 7'b1101101;
      4'h2:    pat = 7'b0100010;
      4'h3:    pat = 7'b0100100;
      4'h4:    pat = 7'b1000101;
      4'h5:    pat = 7'b0010100;
      4'h6:    pat = 7'b0010000;
      4'h7:    pat = 7'b0101101;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0000100;
      4'hA:    pat = 7'b0000001;
      4'hB:    pat = 7'b1010000;
      4'hC:    pat = 7'b0011010;
      4'hD:    pat = 7'b1100000;
      4'hE:    pat = 7'b0010010;
      4'hF:    pat = 7'b0010011;
      default: pat = 7'b1111111;
    endcase
    return pat;
  endfunction

  assign cnt_last = (cnt == CNT_LAST);
  assign boundary = cnt_last && (idx == IDX_LAST);
  assign in_guard = (32'(cnt) < GUARD);
  assign cur_nib  = sh_value[{idx, 2'b00} +: 4];
  assign an_sel   = ~(DIGITS'(1'b1) << idx);
  assign busy     = pend;

  // upper_zero[i] is set when displayed digits i..DIGITS-1 are all zero.
  always_comb begin
    upper_zero = {DIGITS{1'b0}};
    zero_run   = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run & (sh_value[4*i +: 4] == 4'h0);
      upper_zero[i] = zero_run;
    end
  end

  // Drive selection for the current slot from the shadow register.
  always_comb begin
    seg_nxt = 7'b1111111;
    dot_nxt = 1'b1;
    an_nxt  = {DIGITS{1'b1}};
    if (in_guard) begin
      seg_nxt = 7'b1111111;
      dot_nxt = 1'b1;
      an_nxt  = {DIGITS{1'b1}};
    end else if (sh_blank[idx]) begin
      seg_nxt = 7'b1111111;
      dot_nxt = 1'b1;
      an_nxt  = {DIGITS{1'b1}};
    end else if (lzs && (idx != IW'(1'b0)) && upper_zero[idx]) begin
      // Suppressed leading zero keeps its anode so a set decimal point still shows.
      seg_nxt = 7'b1111111;
      dot_nxt = ~sh_dp[idx];
      an_nxt  = an_sel;
    end else begin
      seg_nxt = encode(cur_nib);
      dot_nxt = ~sh_dp[idx];
      an_nxt  = an_sel;
    end
  end

  // Scan counters, load buffering, frame transfer and registered pin drives.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= {CW{1'b0}};
      idx      <= {IW{1'b0}};
      pend     <= 1'b0;
      pb_value <= {(4*DIGITS){1'b0}};
      pb_dp    <= {DIGITS{1'b0}};
      pb_blank <= {DIGITS{1'b0}};
      sh_value <= {(4*DIGITS){1'b0}};
      sh_dp    <= {DIGITS{1'b0}};
      sh_blank <= {DIGITS{1'b0}};
      seg      <= 7'b1111111;
      dot      <= 1'b1;
      an       <= {DIGITS{1'b1}};
      frame    <= 1'b0;
    end else begin
      if (cnt_last) begin
        cnt <= {CW{1'b0}};
        idx <= (idx == IDX_LAST) ? {IW{1'b0}} : idx + IW'(1'b1);
      end else begin
        cnt <= cnt + CW'(1'b1);
      end

      // A boundary transfer reads the old pending buffer even if a load lands on the same edge.
      if (boundary && pend) begin
        sh_value <= pb_value;
        sh_dp    <= pb_dp;
        sh_blank <= pb_blank;
      end

      if (load) begin
        pb_value <= value;
        pb_dp    <= dp;
        pb_blank <= blank;
        pend     <= 1'b1;
      end else if (boundary) begin
        pend     <= 1'b0;
      end

      frame <= boundary;
      seg   <= seg_nxt;
      dot   <= dot_nxt;
      an    <= an_nxt;
    end
  end

  seven_seg_scanner_chk #(.DIGITS(DIGITS)) u_chk (
    .clk (clk),
    .rst (rst),
    .seg (seg),
    .dot (dot),
    .an  (an)
  );

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner at DIGITS=4, CLK_DIV=4, GUARD=1.

module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        load;
  logic        lzs;
  logic [6:0]  seg;
  logic        dot;
  logic [3:0]  an;
  logic        busy;
  logic        frame;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(.DIGITS(4), .CLK_DIV(4), .GUARD(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .dp    (dp),
    .blank (blank),
    .load  (load),
    .lzs   (lzs),
    .seg   (seg),
    .dot   (dot),
    .an    (an),
    .busy  (busy),
    .frame (frame)
  );

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0]      blank;
    logic            lzs;
    logic [3:0][6:0] seg;
    logic [3:0]      dot;
    logic [3:0]      lit;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int k);
    while (cyc < k) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] an_of(input int d);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << d);
  endfunction

  // Frame starting after boundary cycle fb: guard then mid-slot values for each digit.
  task automatic check_frame(input int fb, input logic [3:0][6:0] s,
                             input logic [3:0] dt, input logic [3:0] lit);
    for (int d = 0; d < 4; d++) begin
      wait_until(fb + 1 + 4*d);
      chk($sformatf("guard_an_d%0d", d), an, 4'b1111);
      chk($sformatf("guard_seg_d%0d", d), seg, 7'b1111111);
      wait_until(fb + 3 + 4*d);
      chk($sformatf("an_d%0d", d), an, lit[d] ? an_of(d) : 4'b1111);
      chk($sformatf("seg_d%0d", d), seg, s[d]);
      chk($sformatf("dot_d%0d", d), dot, dt[d]);
    end
  endtask

  // Free-running scan with an all-zero shadow register, starting right after reset.
  task automatic scan_check(input int n);
    int c;
    int ix;
    for (int k = 1; k <= n; k++) begin
      tick();
      c  = (k - 1) % 4;
      ix = ((k - 1) / 4) % 4;
      chk("scan_an", an, (c == 0) ? 4'b1111 : an_of(ix));
      chk("scan_seg", seg, (c == 0) ? 7'b1111111 : 7'b0001000);
      chk("scan_frame", frame, (k % 16 == 0) ? 1'b1 : 1'b0);
      chk("scan_busy", busy, 1'b0);
    end
  endtask

  initial begin
    int base;
    logic [6:0] prev_seg;
    logic       prev_dot;
    logic       prev_lit;

    vecs[0] = '{16'h1A2F, 4'b0010, 4'b0000, 1'b0,
                {7'b1101101, 7'b0000001, 7'b0100010, 7'b0010011}, 4'b1101, 4'b1111};
    vecs[1] = '{16'h0070, 4'b0000, 4'b0000, 1'b1,
                {7'b1111111, 7'b1111111, 7'b0101101, 7'b0001000}, 4'b1111, 4'b1111};
    vecs[2] = '{16'h0070, 4'b0000, 4'b0001, 1'b1,
                {7'b1111111, 7'b1111111, 7'b0101101, 7'b1111111}, 4'b1111, 4'b1110};
    vecs[3] = '{16'h0000, 4'b0100, 4'b0000, 1'b1,
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b0001000}, 4'b1011, 4'b1111};
    vecs[4] = '{16'h3C84, 4'b1001, 4'b0100, 1'b0,
                {7'b0100100, 7'b1111111, 7'b0000000, 7'b1000101}, 4'b0110, 4'b1011};
    vecs[5] = '{16'h9E6D, 4'b0000, 4'b0000, 1'b1,
                {7'b0000100, 7'b0010010, 7'b0010000, 7'b1100000}, 4'b1111, 4'b1111};
    vecs[6] = '{16'h5000, 4'b0000, 4'b0000, 1'b1,
                {7'b0010100, 7'b0001000, 7'b0001000, 7'b0001000}, 4'b1111, 4'b1111};

    rst = 1'b1; load = 1'b0; value = 16'h0000; dp = 4'b0000; blank = 4'b0000; lzs = 1'b0;
    tick();
    tick();
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 7'b1111111);
    chk("rst_dot", dot, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame", frame, 1'b0);
    rst = 1'b0;
    cyc = 0;
    scan_check(16);

    prev_seg = 7'b0001000; prev_dot = 1'b1; prev_lit = 1'b1;
    for (int r = 0; r < NV; r++) begin
      base = 16 + 32*r;
      wait_until(base + 5);
      value = vecs[r].value; dp = vecs[r].dp; blank = vecs[r].blank; load = 1'b1;
      tick();
      load = 1'b0;
      chk("busy_rise", busy, 1'b1);
      wait_until(base + 14);
      chk("hold_an", an, prev_lit ? an_of(3) : 4'b1111);
      chk("hold_seg", seg, prev_seg);
      chk("hold_dot", dot, prev_dot);
      wait_until(base + 15);
      chk("busy_before", busy, 1'b1);
      chk("frame_before", frame, 1'b0);
      tick();
      chk("frame_pulse", frame, 1'b1);
      chk("busy_fall", busy, 1'b0);
      lzs = vecs[r].lzs;
      check_frame(base + 16, vecs[r].seg, vecs[r].dot, vecs[r].lit);
      prev_seg = vecs[r].seg[3]; prev_dot = vecs[r].dot[3]; prev_lit = vecs[r].lit[3];
    end

    // Two loads in one frame: the last one wins.
    base = 16 + 32*NV;
    wait_until(base + 5);
    lzs = 1'b0; dp = 4'b0000; blank = 4'b0000; value = 16'h1111; load = 1'b1;
    tick();
    load = 1'b0;
    wait_until(base + 9);
    value = 16'h2222; load = 1'b1;
    tick();
    load = 1'b0;
    while (cyc < base + 16) begin
      tick();
      chk("no_1111_seen", seg == 7'b1101101, 1'b0);
    end
    chk("busy_after_2load", busy, 1'b0);
    check_frame(base + 16, {4{7'b0100010}}, 4'b1111, 4'b1111);

    // Load on the boundary edge with a pending load already queued.
    base = base + 32;
    wait_until(base + 5);
    value = 16'h4444; load = 1'b1;
    tick();
    load = 1'b0;
    wait_until(base + 15);
    value = 16'h7777; load = 1'b1;
    tick();
    load = 1'b0;
    chk("edge_busy_hold", busy, 1'b1);
    chk("edge_frame", frame, 1'b1);
    check_frame(base + 16, {4{7'b1000101}}, 4'b1111, 4'b1111);
    wait_until(base + 31);
    chk("edge_busy_mid", busy, 1'b1);
    tick();
    chk("edge_busy_fall", busy, 1'b0);
    chk("edge_frame2", frame, 1'b1);
    check_frame(base + 32, {4{7'b0101101}}, 4'b1111, 4'b1111);

    // Reset mid-slot with a load pending and a simultaneous load request.
    base = base + 48;
    wait_until(base + 5);
    value = 16'hBBBB; load = 1'b1;
    tick();
    load = 1'b0;
    wait_until(base + 9);
    chk("pre_rst_busy", busy, 1'b1);
    rst = 1'b1; load = 1'b1; value = 16'hCCCC;
    tick();
    rst = 1'b0; load = 1'b0;
    chk("mid_rst_an", an, 4'b1111);
    chk("mid_rst_seg", seg, 7'b1111111);
    chk("mid_rst_dot", dot, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_frame", frame, 1'b0);
    cyc = 0;
    scan_check(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
